// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared encodings for the MEM-stage load/store unit.
//   size_e  : access size as carried on req_size (byte/half/word/dword)
//   state_e : sequencing states of mem_access_unit
//   size_bytes(size) : number of bytes moved by an access of that size
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RSP
  } state_e;

  function automatic int unsigned size_bytes(input logic [1:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_merge.sv
// lane_merge: combinational byte-lane insert/extract for one memory word.
//   word    : memory word the field lives in
//   lane    : byte lane of the lowest-addressed byte of the field
//   size    : access size (size_e encoding)
//   val     : right-justified value to insert
//   sgn     : sign-extend the extracted field
//   merged  : word with val inserted at the addressed lanes
//   extract : addressed field, right-justified and extended to DATA_W
module lane_merge
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic [DATA_W-1:0]            word,
  input  logic [$clog2(DATA_W/8)-1:0]  lane,
  input  logic [1:0]                   size,
  input  logic [DATA_W-1:0]            val,
  input  logic                         sgn,
  output logic [DATA_W-1:0]            merged,
  output logic [DATA_W-1:0]            extract
);

  localparam int unsigned WBYTES = DATA_W / 8;

  int unsigned       nbytes;
  int unsigned       shift;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] field;
  logic [DATA_W-1:0] top;

  always_comb begin
    nbytes = size_bytes(size);
    if (nbytes > WBYTES) nbytes = WBYTES;

    if (nbytes == WBYTES) mask = '1;
    else                  mask = (DATA_W'(1) << (8 * nbytes)) - DATA_W'(1);

    // Big-endian puts the lowest address at the top, so the field's LSB
    // sits below the last byte of the field rather than at the first one.
    if (BIG_ENDIAN) shift = DATA_W - 8 * (32'(lane) + nbytes);
    else            shift = 8 * 32'(lane);

    field   = (word >> shift) & mask;
    top     = mask & ~(mask >> 1);
    extract = (sgn && |(field & top)) ? (field | ~mask) : field;
    merged  = (word & ~(mask << shift)) | ((val & mask) << shift);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit in front of a word-wide memory
// port without byte enables. Sub-word stores are read-modify-write.
//   req_*  : pipeline request (valid/ready), store data right-justified
//   rsp_*  : response (valid/ready); rdata extended, 0 for stores; err on
//            misaligned or illegal size (no memory access made)
//   mem_*  : word-aligned memory port, held stable until mem_ack
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned WBYTES = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(WBYTES);

  state_e              state_q, state_d;
  logic                we_q, sgn_q, err_q;
  logic [1:0]          size_q;
  logic [LANE_W-1:0]   lane_q;
  logic [DATA_W-1:0]   wdata_q, wword_q, rdata_q;
  logic [ADDR_W-1:0]   maddr_q;

  int unsigned         req_nb;
  logic                req_bad, req_full;
  logic [DATA_W-1:0]   merged, extract;

  always_comb begin
    req_nb   = size_bytes(req_size);
    req_bad  = ((req_size == SZ_D) && (DATA_W == 32)) ||
               ((req_addr[LANE_W-1:0] & LANE_W'(req_nb - 1)) != '0);
    req_full = (req_nb == WBYTES);
  end

  lane_merge #(
    .DATA_W     (DATA_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_merge (
    .word    (mem_rdata),
    .lane    (lane_q),
    .size    (size_q),
    .val     (wdata_q),
    .sgn     (sgn_q),
    .merged  (merged),
    .extract (extract)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                 state_d = RSP;
          else if (req_we && req_full) state_d = WR;
          else                         state_d = RD;
        end
      end
      RD: begin
        mem_req = 1'b1;
        if (mem_ack) state_d = we_q ? WR : RSP;
      end
      WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) state_d = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Merge/extract work directly on mem_rdata in the ack cycle, so the read
  // word itself is never stored: only its merged or extracted form.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      wword_q <= '0;
      rdata_q <= '0;
      maddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          sgn_q   <= req_signed;
          size_q  <= req_size;
          lane_q  <= req_addr[LANE_W-1:0];
          wdata_q <= req_wdata;
          maddr_q <= {req_addr[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
          err_q   <= req_bad;
          rdata_q <= '0;
          if (req_we && req_full) wword_q <= req_wdata;
        end
        RD: if (mem_ack) begin
          if (we_q) wword_q <= merged;
          else      rdata_q <= extract;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = maddr_q;
  assign mem_wdata = wword_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
